// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause bit positions, ExcCodes
// and the exception sequencing states.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  localparam int unsigned SR_IE         = 0;
  localparam int unsigned SR_EXL        = 1;
  localparam int unsigned INT_LSB       = 10;
  localparam int unsigned CAUSE_EXC_LSB = 2;
  localparam int unsigned CAUSE_TI      = 30;
  localparam int unsigned CAUSE_BD      = 31;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_BREAK   = 5'd9;
  localparam logic [4:0] EXC_OV      = 5'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTER = 2'd1,
    DRAIN = 2'd2,
    RET   = 2'd3
  } cp0_state_e;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count free-runs (or loads on write); TI latches when
// the next Count equals Compare and clears on any Compare write.
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  always_comb begin
    count_d   = count_we ? wdata : count_q + 32'd1;
    compare_d = compare_we ? wdata : compare_q;
    // Match against the value Count takes next so TI and Count change together
    ti_d      = compare_we ? 1'b0 : (ti_q | (count_d == compare_q));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= '1;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 controller: CP0 register file, interrupt/exception entry,
// drain and eret return sequencing with PC redirect and pipeline stall.
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_HWINT    = 6,
  parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [31:0] PRID         = 32'h0000_2016
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          pc_i,
  input  logic                 pc_valid,
  input  logic                 bd_i,
  input  logic                 exc_req,
  input  logic [4:0]           exc_code_i,
  input  logic [NUM_HWINT-1:0] hwint,
  input  logic [4:0]           cp_addr,
  input  logic [31:0]          cp_wdata,
  input  logic                 cp_we,
  input  logic                 eret,
  output logic [31:0]          cp_rdata,
  output logic                 redirect,
  output logic [31:0]          redirect_pc,
  output logic                 exc_stall,
  output logic                 timer_irq
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  cp0_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ie_q, ie_d;
  logic                 exl_q, exl_d;
  logic [NUM_HWINT-1:0] im_q, im_d;
  logic [NUM_HWINT-1:0] ip_q, ip_d;
  logic [4:0]           exc_code_q, exc_code_d;
  logic                 bd_q, bd_d;
  logic [31:0]          epc_q, epc_d;

  logic        count_we, compare_we, ti;
  logic [31:0] count, compare;
  logic        pending;
  logic [31:0] sr_val, cause_val;

  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (count_we),
    .compare_we (compare_we),
    .wdata      (cp_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_comb begin
    ip_d = hwint;
    ip_d[NUM_HWINT-1] = hwint[NUM_HWINT-1] | ti;
    pending = ((ip_q & im_q) != '0) && ie_q && !exl_q && pc_valid;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ie_d        = ie_q;
    exl_d       = exl_q;
    im_d        = im_q;
    exc_code_d  = exc_code_q;
    bd_d        = bd_q;
    epc_d       = epc_q;
    count_we    = 1'b0;
    compare_we  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    exc_stall   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (exc_req || pending) begin
          state_d    = ENTER;
          exc_code_d = exc_req ? exc_code_i : EXC_INT;
          // A nested exception keeps the original return context
          if (!exl_q) begin
            epc_d = bd_i ? (pc_i - 32'd4) : pc_i;
            bd_d  = bd_i;
            exl_d = 1'b1;
          end
        end else if (eret && exl_q) begin
          exl_d   = 1'b0;
          state_d = RET;
        end else if (cp_we) begin
          unique case (cp_addr)
            REG_COUNT:   count_we   = 1'b1;
            REG_COMPARE: compare_we = 1'b1;
            REG_SR: begin
              ie_d  = cp_wdata[SR_IE];
              exl_d = cp_wdata[SR_EXL];
              im_d  = cp_wdata[INT_LSB +: NUM_HWINT];
            end
            REG_EPC:     epc_d = cp_wdata;
            default: ;
          endcase
        end
      end
      ENTER: begin
        redirect    = 1'b1;
        redirect_pc = HANDLER_PC;
        exc_stall   = 1'b1;
        state_d     = DRAIN;
        cnt_d       = CNT_W'(DRAIN_CYCLES - 1);
      end
      DRAIN: begin
        exc_stall = 1'b1;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RET: begin
        redirect    = 1'b1;
        redirect_pc = epc_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ie_q       <= 1'b0;
      exl_q      <= 1'b0;
      im_q       <= '0;
      ip_q       <= '0;
      exc_code_q <= '0;
      bd_q       <= 1'b0;
      epc_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ie_q       <= ie_d;
      exl_q      <= exl_d;
      im_q       <= im_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      bd_q       <= bd_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    sr_val = '0;
    sr_val[SR_IE]  = ie_q;
    sr_val[SR_EXL] = exl_q;
    sr_val[INT_LSB +: NUM_HWINT] = im_q;

    cause_val = '0;
    cause_val[CAUSE_EXC_LSB +: 5]   = exc_code_q;
    cause_val[INT_LSB +: NUM_HWINT] = ip_q;
    cause_val[CAUSE_TI]             = ti;
    cause_val[CAUSE_BD]             = bd_q;

    unique case (cp_addr)
      REG_COUNT:   cp_rdata = count;
      REG_COMPARE: cp_rdata = compare;
      REG_SR:      cp_rdata = sr_val;
      REG_CAUSE:   cp_rdata = cause_val;
      REG_EPC:     cp_rdata = epc_q;
      REG_PRID:    cp_rdata = PRID;
      default:     cp_rdata = '0;
    endcase
  end

  assign timer_irq = ti;

endmodule
